// File: rtl/prio_pkg.sv
// Shared constants, FSM state type and width helper for the interrupt priority controller.
package prio_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } prio_state_e;

    function automatic int prio_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational N-wide priority search: descends from start_i, wrapping from 0 to N-1.
module prio_enc_n
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = prio_clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         none_o
);

    int j;

    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start_i) - k;
            if (j < 0) j = j + N;
            if (none_o && vec_i[j]) begin
                idx_o  = W'(j);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Registered priority controller: sticky pending bits, masking, valid/ack grant handshake,
// fixed or round-robin selection.
//   state    | meaning
//   ST_IDLE  | no grant outstanding (valid=0)
//   ST_GRANT | code holds a granted index (valid=1) until ack
module irq_prio_ctrl
    import prio_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int RR = 0,
    localparam int W  = prio_clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] code,
    output logic         z
);

    localparam logic [W-1:0] TOP_IDX = W'(N - 1);

    prio_state_e  state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] code_q, code_d;
    logic [W-1:0] last_q, last_d;

    logic [N-1:0] elig, clr, sel_vec;
    logic [W-1:0] base, start_rr, start, win;
    logic         grant_ack, none;

    assign grant_ack = (state_q == ST_GRANT) && ack;
    assign elig      = pending_q & ~mask;
    assign clr       = grant_ack ? ({{(N-1){1'b0}}, 1'b1} << code_q) : '0;
    assign pending_d = (pending_q & ~clr) | req;

    // On ack the acked line only competes again if it is re-requested this very cycle.
    assign sel_vec = (state_q == ST_GRANT) ? ((elig & ~clr) | (req & clr & ~mask)) : elig;

    // The round-robin start uses the line being acked now, so alternation has no lag.
    assign base     = grant_ack ? code_q : last_q;
    assign start_rr = (base == '0) ? TOP_IDX : base - W'(1);
    assign start    = (RR == PRIO_RR) ? start_rr : TOP_IDX;

    prio_enc_n #(.N(N)) u_enc (
        .vec_i   (sel_vec),
        .start_i (start),
        .idx_o   (win),
        .none_o  (none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            code_q    <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (!none) begin
                    state_d = ST_GRANT;
                    code_d  = win;
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    if (RR == PRIO_RR) last_d = code_q;
                    if (!none) code_d  = win;
                    else       state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid = (state_q == ST_GRANT);
        code  = code_q;
        z     = ~|elig;
    end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: a fixed-priority and a round-robin instance share stimulus.
module tb_irq_prio_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       valid_fx, valid_rr;
    logic [2:0] code_fx, code_rr;
    logic       z_fx, z_rr;

    int total = 0;
    int bad   = 0;

    irq_prio_ctrl #(.N(8), .RR(0)) dut_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .mask  (mask),
        .ack   (ack),
        .valid (valid_fx),
        .code  (code_fx),
        .z     (z_fx)
    );

    irq_prio_ctrl #(.N(8), .RR(1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .mask  (mask),
        .ack   (ack),
        .valid (valid_rr),
        .code  (code_rr),
        .z     (z_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic v, input logic [2:0] c, input logic zz);
        chk({tag, "_fx_valid"}, {7'b0, valid_fx}, {7'b0, v});
        chk({tag, "_fx_code"},  {5'b0, code_fx},  {5'b0, c});
        chk({tag, "_fx_z"},     {7'b0, z_fx},     {7'b0, zz});
        chk({tag, "_rr_valid"}, {7'b0, valid_rr}, {7'b0, v});
        chk({tag, "_rr_code"},  {5'b0, code_rr},  {5'b0, c});
        chk({tag, "_rr_z"},     {7'b0, z_rr},     {7'b0, zz});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        mask  = '0;
        ack   = 1'b0;
        #1;
        chk_both("reset", 1'b0, 3'd0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk_both("post_reset_idle", 1'b0, 3'd0, 1'b1);

        // fixed order / back-to-back
        req = 8'b0010_0100;
        tick();
        req = '0;
        chk_both("b2b_pending", 1'b0, 3'd0, 1'b0);
        tick();
        chk_both("b2b_first", 1'b1, 3'd5, 1'b0);
        ack = 1'b1;
        tick();
        chk_both("b2b_second", 1'b1, 3'd2, 1'b0);
        tick();
        ack = 1'b0;
        chk_both("b2b_drain", 1'b0, 3'd2, 1'b1);

        // mask blocks winning but pending is still captured
        mask = 8'h80;
        req  = 8'h82;
        tick();
        req = '0;
        chk_both("mask_pending", 1'b0, 3'd2, 1'b0);
        tick();
        chk_both("mask_grant1", 1'b1, 3'd1, 1'b0);
        mask = '0;
        ack  = 1'b1;
        tick();
        chk_both("mask_grant7", 1'b1, 3'd7, 1'b0);
        tick();
        ack = 1'b0;
        chk_both("mask_drain", 1'b0, 3'd7, 1'b1);

        // held requests with ack held: fixed repeats 7, round-robin alternates
        req = 8'h81;
        ack = 1'b1;
        tick();
        chk("hold_idle_fx", {7'b0, valid_fx}, 8'h00);
        chk("hold_idle_rr", {7'b0, valid_rr}, 8'h00);
        tick();
        chk("hold0_fx", {5'b0, code_fx}, 8'd7);
        chk("hold0_rr", {5'b0, code_rr}, 8'd0);
        tick();
        chk("hold1_fx", {5'b0, code_fx}, 8'd7);
        chk("hold1_rr", {5'b0, code_rr}, 8'd7);
        tick();
        chk("hold2_fx", {5'b0, code_fx}, 8'd7);
        chk("hold2_rr", {5'b0, code_rr}, 8'd0);
        tick();
        chk("hold3_fx", {5'b0, code_fx}, 8'd7);
        chk("hold3_rr", {5'b0, code_rr}, 8'd7);
        chk("hold3_fx_valid", {7'b0, valid_fx}, 8'h01);
        chk("hold3_rr_valid", {7'b0, valid_rr}, 8'h01);
        req = '0;
        ack = 1'b0;

        // asynchronous reset in the middle of a grant
        do_reset();
        req = 8'h20;
        tick();
        req = '0;
        tick();
        chk_both("rst_grant", 1'b1, 3'd5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_both("rst_async", 1'b0, 3'd0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk_both("rst_no_regrant", 1'b0, 3'd0, 1'b1);

        // set wins over clear on the acked line
        req = 8'h08;
        tick();
        req = '0;
        tick();
        chk_both("soc_grant", 1'b1, 3'd3, 1'b0);
        ack = 1'b1;
        req = 8'h08;
        tick();
        ack = 1'b0;
        req = '0;
        chk_both("soc_regrant", 1'b1, 3'd3, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_both("soc_drain", 1'b0, 3'd3, 1'b1);

        // masking the granted line keeps the grant until ack
        req = 8'h10;
        tick();
        req = '0;
        tick();
        chk_both("mg_grant", 1'b1, 3'd4, 1'b0);
        mask = 8'h10;
        #1;
        chk_both("mg_masked", 1'b1, 3'd4, 1'b1);
        tick();
        chk_both("mg_held", 1'b1, 3'd4, 1'b1);
        ack = 1'b1;
        tick();
        ack  = 1'b0;
        mask = '0;
        #1;
        chk_both("mg_cleared", 1'b0, 3'd4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_prio_ctrl.md
# irq_prio_ctrl

Parametrised, registered priority controller: latches N request lines into a pending register, applies a per-line mask, and presents one winning index at a time through a valid/ack handshake. It is the sequential successor of the 8-bit combinational priority encoder. It adds arbitrary width, sticky pending state, masking, back-to-back grants and an optional round-robin mode. It sits between interrupt/request sources and a single serving agent (CPU or sequencer).

## Interface
- `N`, 8 — number of request lines, 2..64.
- `RR`, 0 — 0: fixed priority, highest index wins; 1: round-robin.
- `W`, `$clog2(N)` — localparam, code width; not overridable.

- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req` in N — request pulses or levels; a 1 in any cycle sets the pending bit.
- `mask` in N — 1 blocks the line from winning; pending bits are still captured.
- `ack` in 1 — consumer accepts current grant; ignored when `valid`=0.
- `valid` out 1 — `code` holds a granted index.
- `code` out W — index of the granted line; stable while `valid`=1 and `ack`=0.
- `z` out 1 — 1 when no unmasked pending bit exists.

## Operation
- Reset values:
  - `pending`=0, `valid`=0, `code`=0, `z`=1.
  - RR pointer `last`=0, so the first round-robin priority order equals fixed order.
- Pending update each edge: `pending <= (pending & ~clr) | req`.
  - `clr` is a one-hot of `code` when `valid & ack`, else 0.
  - Set wins over clear on the same bit.
- `elig = pending & ~mask`. `z = ~|elig` is combinational from registered `pending` and the live `mask`.
- Winner selection:
  - Fixed mode: highest set index of `elig`.
  - RR mode: search starts at index `(last-1) mod N`, descends, and wraps from 0 to N-1.
- States, encoded by `valid`:
  - IDLE (`valid`=0): if `elig` ≠ 0, the next edge loads `code` with the winner and sets `valid`=1.
  - GRANT (`valid`=1):
    - `code` is held.
    - On `ack`, the winner is computed from `elig` with the acked bit cleared, plus any `req` arriving that cycle only if it re-sets that same bit.
    - If that winner is nonzero, load it and stay in GRANT (back-to-back). Otherwise go to IDLE with `code` unchanged.
    - In RR mode, `last <= code` on every ack.
- Masking the granted line while `valid`=1 does not withdraw the grant; it completes on `ack`.
- Unmasked lines that are not pending do nothing. `mask` changes affect only the next selection.

## Timing
- `req` asserted at cycle t:
  - `pending` bit set at t+1.
  - `valid`/`code` at t+2 if IDLE and the line wins.
- `ack` sampled at edge a: the next `code` is valid at a+1 with no bubble when another line is eligible. Otherwise `valid`=0 at a+1.
- Sustained throughput: one grant per cycle with `ack` held high.
- `rst_n` low clears all state immediately, mid-grant included. The first grant after release comes no earlier than 2 edges after a request.

## Structure
- Package `prio_pkg`: mode constants `PRIO_FIXED`=0, `PRIO_RR`=1; function `prio_clog2`.
- Sub-module `prio_enc_n`: combinational, parametrised by `N`. Inputs are a vector and a start index; outputs are the found index and a `none` flag, using a descending search with wrap. It is instantiated once, with start = N-1 in fixed mode and `(last-1) mod N` in RR mode.
- Top level holds the `pending`, `valid`, `code` and `last` registers plus the handshake logic.

## Test plan
1. **Reset.** Drive `rst_n`=0 mid-grant with `code`=5 → asynchronously `valid`=0, `code`=0, `z`=1. After release, no grant until a new `req`.
2. **Fixed, back-to-back.** N=8, RR=0, one-cycle `req`=8'b0010_0100 → `valid`=1 with `code`=5 two cycles later. Hold `ack`=1 → `code`=2 next cycle, then `valid`=0 and `z`=1.
3. **Mask.** `mask`=8'h80, pulse `req`=8'h82 → `code`=1 and `z`=0. Clear `mask`, then `ack` → `code`=7 next cycle.
4. **Round-robin.** RR=1, `req`=8'h81 held, `ack` held → grants 7, 0, 7, 0, …. The same stimulus with RR=0 → 7 every cycle.
5. **Set-over-clear.** With `code`=3 granted, assert `ack` and `req[3]` in the same cycle → `pending[3]` stays 1 and 3 is granted again next cycle when it is the only line pending.
6. **Mask granted line.** With `code`=4 granted, set `mask[4]`=1 → `code` stays 4 until `ack`, then `pending[4]` is cleared.
